// File: rtl/md_sched_if.sv
// E-stage multiply/divide bus: issue operands and controls in, stall and HI/LO out.
interface md_sched_if;
  logic        IntReq;
  logic [2:0]  E_md_op;
  logic        D_md_use;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output IntReq, E_md_op, D_md_use, A, B,
    input  start, busy, md_stall, HI, LO
  );

  modport slave (
    input  IntReq, E_md_op, D_md_use, A, B,
    output start, busy, md_stall, HI, LO
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide scheduler: computes the result at issue, holds it for a fixed
// busy period, then commits it to HI/LO. Interrupt-flushed ops never start.
module md_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave bus
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      hi_q, hi_n, lo_q, lo_n;
  logic [31:0]      pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic             pend_wr, pend_wr_n;

  logic             accept, start, is_div;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      b_nz, q_s, r_s, q_u, r_u;
  logic [63:0]      result;

  // Dividing by a forced nonzero divisor keeps the datapath defined when B==0;
  // that result is never committed.
  always_comb begin
    b_nz   = (bus.B == 32'd0) ? 32'd1 : bus.B;
    prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    q_u    = bus.A / b_nz;
    r_u    = bus.A % b_nz;
    if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
      q_s = 32'h8000_0000;
      r_s = 32'd0;
    end else begin
      q_s = $signed(bus.A) / $signed(b_nz);
      r_s = $signed(bus.A) % $signed(b_nz);
    end
    case (bus.E_md_op)
      3'd1:    result = prod_s;
      3'd2:    result = prod_u;
      3'd3:    result = {r_s, q_s};
      3'd4:    result = {r_u, q_u};
      default: result = 64'd0;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi_q;
    lo_n      = lo_q;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_wr_n = pend_wr;
    accept    = (state == IDLE) && !bus.IntReq;
    start     = accept && (bus.E_md_op >= 3'd1) && (bus.E_md_op <= 3'd4);
    is_div    = (bus.E_md_op == 3'd3) || (bus.E_md_op == 3'd4);
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = RUN;
          cnt_n     = is_div ? DIV_LOAD : MULT_LOAD;
          pend_hi_n = result[63:32];
          pend_lo_n = result[31:0];
          pend_wr_n = !(is_div && bus.B == 32'd0);
        end else if (accept && bus.E_md_op == 3'd5) begin
          hi_n = bus.A;
        end else if (accept && bus.E_md_op == 3'd6) begin
          lo_n = bus.A;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_n = IDLE;
          if (pend_wr) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_wr <= pend_wr_n;
    end
  end

  assign bus.start    = start;
  assign bus.busy     = (state == RUN);
  assign bus.md_stall = bus.D_md_use && (start || (state == RUN));
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: expected HI/LO are queued at issue and compared
// at commit, with busy length, stall and hold behaviour checked on the way.
module tb_md_sched;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_sched_if bus ();

  md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  hilo_t       sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic irq, input logic duse);
    bus.E_md_op  = op;
    bus.A        = a;
    bus.B        = b;
    bus.IntReq   = irq;
    bus.D_md_use = duse;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issues one op at the current cycle and follows it to its commit; returns on
  // the first cycle with busy low so a following op lands back-to-back.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_cyc, input bit mid_irq);
    hilo_t e;
    int    n;
    applyStimulus(op, a, b, 1'b0, 1'b1);
    #1;
    checkOutput("start", 32'(bus.start), 32'd1);
    checkOutput("stall_start", 32'(bus.md_stall), 32'd1);
    sb.push_back('{hi: exp_hi, lo: exp_lo});
    n = 0;
    @(negedge clk);
    applyStimulus(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    while (bus.busy === 1'b1 && n < 64) begin
      checkOutput("stall_busy", 32'(bus.md_stall), 32'd1);
      checkOutput("hi_hold", bus.HI, model_hi);
      checkOutput("lo_hold", bus.LO, model_lo);
      n++;
      @(negedge clk);
      applyStimulus(3'd0, 32'd0, 32'd0, mid_irq && (n == 2), 1'b1);
      #1;
    end
    checkOutput("busy_cycles", 32'(n), 32'(exp_cyc));
    checkOutput("stall_drop", 32'(bus.md_stall), 32'd0);
    e = sb.pop_front();
    checkOutput("hi_commit", bus.HI, e.hi);
    checkOutput("lo_commit", bus.LO, e.lo);
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_hi", bus.HI, 32'd0);
    checkOutput("rst_lo", bus.LO, 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_start", 32'(bus.start), 32'd0);
    checkOutput("rst_stall", 32'(bus.md_stall), 32'd0);

    @(negedge clk);
    run_md(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0);
    run_md(3'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, 1'b0);
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
    run_md(3'd4, 32'd7, 32'd0, model_hi, model_lo, 10, 1'b0);
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0);

    // Flushed mult and flushed mthi must leave no trace.
    applyStimulus(3'd1, 32'd5, 32'd5, 1'b1, 1'b0);
    #1;
    checkOutput("irq_start", 32'(bus.start), 32'd0);
    @(negedge clk);
    applyStimulus(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput("irq_busy", 32'(bus.busy), 32'd0);
    checkOutput("irq_hi", bus.HI, model_hi);
    checkOutput("irq_lo", bus.LO, model_lo);
    applyStimulus(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput("irq_mthi", bus.HI, model_hi);

    applyStimulus(3'd6, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput("mtlo_start", 32'(bus.start), 32'd0);
    @(negedge clk);
    applyStimulus(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput("mtlo_lo", bus.LO, 32'h1234_5678);
    checkOutput("mtlo_busy", 32'(bus.busy), 32'd0);
    model_lo = 32'h1234_5678;
    applyStimulus(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput("mthi_hi", bus.HI, 32'hCAFE_F00D);
    checkOutput("mthi_lo", bus.LO, model_lo);
    model_hi = 32'hCAFE_F00D;

    run_md(3'd1, 32'd7, 32'd6, 32'd0, 32'd42, 5, 1'b1);

    // Reset on the fourth busy cycle of a divide discards it.
    applyStimulus(3'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    #1;
    checkOutput("rdiv_start", 32'(bus.start), 32'd1);
    @(negedge clk);
    applyStimulus(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rdiv_busy4", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rdiv_busy", 32'(bus.busy), 32'd0);
    checkOutput("rdiv_hi", bus.HI, 32'd0);
    checkOutput("rdiv_lo", bus.LO, 32'd0);
    checkOutput("rdiv_stall", 32'(bus.md_stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checkOutput("rdiv_post_hi", bus.HI, 32'd0);
    checkOutput("rdiv_post_lo", bus.LO, 32'd0);
    checkOutput("rdiv_post_busy", 32'(bus.busy), 32'd0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
